// File: rtl/knap_pkg.sv
// Shared types and helpers for the exhaustive multi-constraint knapsack solver.
package knap_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DIM_VALUE = 0;

  // Sum width large enough that adding every item's largest coefficient never wraps.
  function automatic int acc_width(input int coef_w, input int n_items);
    return coef_w + $clog2(n_items + 1);
  endfunction

endpackage

// File: rtl/knap_subset_sum.sv
// Stage 1: registered sum of the coefficients selected by a subset mask, for one dimension.
module knap_subset_sum
  import knap_pkg::*;
#(
  parameter int N_ITEMS = 13,
  parameter int COEF_W  = 8,
  parameter int ACC_W   = acc_width(COEF_W, N_ITEMS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_ITEMS-1:0]              mask,
  input  logic [N_ITEMS-1:0][COEF_W-1:0]  coef,
  output logic [ACC_W-1:0]                sum_q
);

  logic [ACC_W-1:0] sum_d;

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (mask[i]) begin
        sum_d = sum_d + ACC_W'(coef[i]);
      end else begin
        sum_d = sum_d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

endmodule

// File: rtl/knap_multi_search.sv
// Exhaustive 0/1 knapsack solver: sweeps every subset through a 2-stage pipeline.
// Optional KNAP_FEAS_COUNT_EN adds a saturating count of feasible subsets.
module knap_multi_search
  import knap_pkg::*;
#(
  parameter int  N_ITEMS = 13,
  parameter int  N_DIMS  = 2,
  parameter int  COEF_W  = 8,
  localparam int ACC_W   = acc_width(COEF_W, N_ITEMS),
  localparam int IDX_W   = $clog2(N_ITEMS),
  localparam int DIM_W   = $clog2(N_DIMS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_item,
  input  logic [DIM_W-1:0]   cfg_dim,
  input  logic [COEF_W-1:0]  cfg_data,
  input  logic               lim_we,
  input  logic [DIM_W-1:0]   lim_dim,
  input  logic [ACC_W-1:0]   lim_data,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               best_valid,
  output logic [N_ITEMS-1:0] best_mask,
  output logic [ACC_W-1:0]   best_value,
  output logic [N_ITEMS:0]   feas_count
);

  localparam logic [N_ITEMS:0] CNT_LAST = {1'b0, {N_ITEMS{1'b1}}};

  logic [N_DIMS:0][N_ITEMS-1:0][COEF_W-1:0] coef_q, coef_d;
  logic [N_DIMS:0][ACC_W-1:0]               lim_q, lim_d;
  state_t                                   state_q, state_d;
  logic [N_ITEMS:0]                         cnt_q, cnt_d;
  logic                                     s1_valid_q, s1_valid_d;
  logic [N_ITEMS-1:0]                       s1_mask_q, s1_mask_d;
  logic                                     best_valid_q, best_valid_d;
  logic [N_ITEMS-1:0]                       best_mask_q, best_mask_d;
  logic [ACC_W-1:0]                         best_value_q, best_value_d;
  logic                                     busy_q, busy_d;
  logic                                     done_q, done_d;
  logic                                     start_accept_s;
  logic                                     feasible_s;
  logic [ACC_W-1:0]                         sum_s [N_DIMS+1];

  for (genvar d = 0; d <= N_DIMS; d++) begin : g_dim
    knap_subset_sum #(
      .N_ITEMS (N_ITEMS),
      .COEF_W  (COEF_W),
      .ACC_W   (ACC_W)
    ) u_sum (
      .clk   (clk),
      .rst   (rst),
      .mask  (cnt_q[N_ITEMS-1:0]),
      .coef  (coef_q[d]),
      .sum_q (sum_s[d])
    );
  end

  // Configuration writes are only honoured while no sweep is running.
  always_comb begin
    coef_d = coef_q;
    lim_d  = lim_q;
    if (cfg_we && !busy_q && (32'(cfg_item) < N_ITEMS) && (32'(cfg_dim) <= N_DIMS)) begin
      coef_d[cfg_dim][cfg_item] = cfg_data;
    end else begin
      coef_d = coef_q;
    end
    if (lim_we && !busy_q && (32'(lim_dim) <= N_DIMS)) begin
      lim_d[lim_dim] = lim_data;
    end else begin
      lim_d = lim_q;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    start_accept_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d        = SWEEP;
          cnt_d          = '0;
          start_accept_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      SWEEP: begin
        cnt_d = cnt_q + (N_ITEMS+1)'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = DRAIN;
        end else begin
          state_d = SWEEP;
        end
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage 2: value must reach the minimum, every cost must stay within its limit.
  always_comb begin
    feasible_s = (sum_s[DIM_VALUE] >= lim_q[DIM_VALUE]);
    for (int k = 1; k <= N_DIMS; k++) begin
      if (sum_s[k] > lim_q[k]) begin
        feasible_s = 1'b0;
      end else begin
        feasible_s = feasible_s;
      end
    end
  end

  always_comb begin
    s1_valid_d   = (state_q == SWEEP);
    s1_mask_d    = cnt_q[N_ITEMS-1:0];
    best_valid_d = best_valid_q;
    best_mask_d  = best_mask_q;
    best_value_d = best_value_q;
    busy_d       = (state_d == SWEEP) || (state_d == DRAIN);
    done_d       = (state_q == DONE);
    if (start_accept_s) begin
      best_valid_d = 1'b0;
      best_mask_d  = '0;
      best_value_d = '0;
    // Strict greater-than keeps the lowest mask among equal-value subsets.
    end else if (s1_valid_q && feasible_s &&
                 (!best_valid_q || (sum_s[DIM_VALUE] > best_value_q))) begin
      best_valid_d = 1'b1;
      best_mask_d  = s1_mask_q;
      best_value_d = sum_s[DIM_VALUE];
    end else begin
      best_valid_d = best_valid_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coef_q       <= '0;
      lim_q        <= '0;
      state_q      <= IDLE;
      cnt_q        <= '0;
      s1_valid_q   <= 1'b0;
      s1_mask_q    <= '0;
      best_valid_q <= 1'b0;
      best_mask_q  <= '0;
      best_value_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      coef_q       <= coef_d;
      lim_q        <= lim_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      s1_valid_q   <= s1_valid_d;
      s1_mask_q    <= s1_mask_d;
      best_valid_q <= best_valid_d;
      best_mask_q  <= best_mask_d;
      best_value_q <= best_value_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

`ifdef KNAP_FEAS_COUNT_EN
  localparam logic [N_ITEMS:0] FEAS_MAX = {1'b1, {N_ITEMS{1'b0}}};
  logic [N_ITEMS:0] feas_q, feas_d;

  always_comb begin
    feas_d = feas_q;
    if (start_accept_s) begin
      feas_d = '0;
    end else if (s1_valid_q && feasible_s && (feas_q != FEAS_MAX)) begin
      feas_d = feas_q + (N_ITEMS+1)'(1);
    end else begin
      feas_d = feas_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      feas_q <= '0;
    end else begin
      feas_q <= feas_d;
    end
  end

  assign feas_count = feas_q;
`else
  assign feas_count = '0;
`endif

  assign busy       = busy_q;
  assign done       = done_q;
  assign best_valid = best_valid_q;
  assign best_mask  = best_mask_q;
  assign best_value = best_value_q;

endmodule

// File: tb/tb_knap_multi_search.sv
// Scoreboard bench for knap_multi_search: expected results come from a brute-force subset model.
module tb_knap_multi_search;
  import knap_pkg::*;

  localparam int NI = 4;
  localparam int ND = 2;
  localparam int CW = 8;
  localparam int AW = acc_width(CW, NI);
  localparam int IW = $clog2(NI);
  localparam int DW = $clog2(ND + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_we, lim_we, start;
  logic [IW-1:0] cfg_item;
  logic [DW-1:0] cfg_dim, lim_dim;
  logic [CW-1:0] cfg_data;
  logic [AW-1:0] lim_data;
  logic          busy, done, best_valid;
  logic [NI-1:0] best_mask;
  logic [AW-1:0] best_value;
  logic [NI:0]   feas_count;

  knap_multi_search #(.N_ITEMS(NI), .N_DIMS(ND), .COEF_W(CW)) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_item(cfg_item), .cfg_dim(cfg_dim), .cfg_data(cfg_data),
    .lim_we(lim_we), .lim_dim(lim_dim), .lim_data(lim_data),
    .start(start), .busy(busy), .done(done),
    .best_valid(best_valid), .best_mask(best_mask), .best_value(best_value),
    .feas_count(feas_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int bv;
    int mask;
    int val;
    int feas;
    int cyc;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  int   nvec  = 0;
  int   nfail = 0;
  int   mc[ND+1][NI];
  int   ml[ND+1];

  task automatic chk(input string nm, input longint act, input longint exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Enumerate every subset directly from the rules: highest value wins, first found on ties.
  function automatic exp_t model_run();
    exp_t e;
    e.bv = 0; e.mask = 0; e.val = 0; e.feas = 0; e.cyc = 0;
    for (int m = 0; m < (1 << NI); m++) begin
      int s[ND+1];
      bit ok;
      for (int d = 0; d <= ND; d++) begin
        s[d] = 0;
        for (int i = 0; i < NI; i++) if (((m >> i) & 1) == 1) s[d] += mc[d][i];
      end
      ok = (s[0] >= ml[0]);
      for (int k = 1; k <= ND; k++) if (s[k] > ml[k]) ok = 1'b0;
      if (ok) begin
        e.feas++;
        if (e.bv == 0 || s[0] > e.val) begin
          e.bv = 1; e.mask = m; e.val = s[0];
        end
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      if (sb.size() == 0) begin
        nvec++; nfail++;
        $display("FAIL unexpected_done: got done=1, expected no completion (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("done_latency", longint'(cyc), longint'(e.cyc));
        chk("best_valid", longint'(best_valid), longint'(e.bv));
        chk("best_mask", longint'(best_mask), longint'(e.mask));
        chk("best_value", longint'(best_value), longint'(e.val));
`ifdef KNAP_FEAS_COUNT_EN
        chk("feas_count", longint'(feas_count), longint'(e.feas));
`else
        chk("feas_count", longint'(feas_count), 0);
`endif
        last = e;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wcfg(input int item, input int dim, input int data, input bit upd);
    cfg_we = 1'b1; cfg_item = IW'(item); cfg_dim = DW'(dim); cfg_data = CW'(data);
    if (upd) mc[dim][item] = data;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic wlim(input int dim, input int data);
    lim_we = 1'b1; lim_dim = DW'(dim); lim_data = AW'(data);
    ml[dim] = data;
    tick();
    lim_we = 1'b0;
  endtask

  task automatic load(input int v[NI], input int w[NI], input int u[NI],
                      input int mn, input int mw, input int mu);
    for (int i = 0; i < NI; i++) begin
      wcfg(i, 0, v[i], 1'b1);
      wcfg(i, 1, w[i], 1'b1);
      wcfg(i, 2, u[i], 1'b1);
    end
    wlim(0, mn); wlim(1, mw); wlim(2, mu);
  endtask

  // Accept edge is the next posedge; done shows 2^NI+2 edges after it.
  task automatic start_sweep();
    exp_t e;
    e = model_run();
    e.cyc = cyc + 1 + (1 << NI) + 2;
    sb.push_back(e);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      nvec++; nfail++;
      $display("FAIL done_timeout: got no done within 200 cycles, expected done pulse");
      sb.delete();
    end
    tick();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, longint'(busy), 0);
    chk({tag, "_done"}, longint'(done), 0);
    chk({tag, "_valid"}, longint'(best_valid), 0);
    chk({tag, "_mask"}, longint'(best_mask), 0);
    chk({tag, "_value"}, longint'(best_value), 0);
    chk({tag, "_feas"}, longint'(feas_count), 0);
  endtask

  task automatic chk_hold();
    repeat (3) tick();
    chk("hold_busy", longint'(busy), 0);
    chk("hold_mask", longint'(best_mask), longint'(last.mask));
    chk("hold_value", longint'(best_value), longint'(last.val));
  endtask

  initial begin
    int bv[NI] = '{4, 8, 0, 20};
    int bw[NI] = '{28, 8, 27, 18};
    int bu[NI] = '{27, 27, 4, 4};
    int rv[NI], rw[NI], ru[NI];
    rst = 1'b1; cfg_we = 1'b0; lim_we = 1'b0; start = 1'b0;
    cfg_item = '0; cfg_dim = '0; cfg_data = '0; lim_dim = '0; lim_data = '0;
    for (int d = 0; d <= ND; d++) begin
      ml[d] = 0;
      for (int i = 0; i < NI; i++) mc[d][i] = 0;
    end
    repeat (3) tick();
    chk_zero("reset");
    rst = 1'b0;
    tick();
    chk_zero("post_reset");

    load(bv, bw, bu, 10, 30, 35);
    start_sweep(); wait_done(); chk_hold();

    wlim(0, 100);
    start_sweep(); wait_done();

    load('{5, 5, 0, 0}, '{10, 10, 0, 0}, '{0, 0, 0, 0}, 1, 10, 255);
    start_sweep(); wait_done();

    load('{255, 255, 255, 255}, '{255, 255, 255, 255}, '{255, 255, 255, 255}, 0, 1020, 1020);
    start_sweep(); wait_done();

    // Start and a config write while busy must both be ignored.
    load(bv, bw, bu, 10, 30, 35);
    start_sweep();
    repeat (5) tick();
    start = 1'b1; tick(); start = 1'b0;
    wcfg(3, 0, 200, 1'b0);
    wait_done();
    wcfg(3, 0, 200, 1'b1);
    start_sweep(); wait_done();
    chk("second_value", longint'(best_value), 208);

    // Write and start in the same idle cycle: the sweep must see the new value.
    cfg_we = 1'b1; cfg_item = IW'(3); cfg_dim = DW'(0); cfg_data = CW'(20);
    mc[0][3] = 20;
    start_sweep();
    cfg_we = 1'b0;
    wait_done();

    start_sweep();
    repeat (7) tick();
    rst = 1'b1;
    sb.delete();
    tick();
    chk_zero("midsweep_reset");
    rst = 1'b0;
    for (int d = 0; d <= ND; d++) begin
      ml[d] = 0;
      for (int i = 0; i < NI; i++) mc[d][i] = 0;
    end
    tick();
    chk_zero("after_abort");
    start_sweep(); wait_done();

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NI; i++) begin
        rv[i] = $urandom_range(0, 255);
        rw[i] = $urandom_range(0, 255);
        ru[i] = $urandom_range(0, 255);
      end
      load(rv, rw, ru, $urandom_range(0, 400), $urandom_range(0, 800), $urandom_range(0, 800));
      start_sweep(); wait_done();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/knap_multi_search.md
Name: knap_multi_search

Overview:
- Parametrised exhaustive multi-constraint 0/1 knapsack solver.
- Holds per-item value and N_DIMS cost coefficients, plus one minimum-value limit and N_DIMS cost limits, in registers loaded over a config port.
- On start, sweeps every subset mask 0..2^N_ITEMS-1 at one subset per cycle through a 2-stage pipeline.
- Reports the best feasible subset: highest value, with every cost within its limit and value at or above the minimum.
- Successor to the fixed 13-item, 8-bit, value/weight/volume combinational checker: generalised in item count, constraint count and width, with no accumulator wrap.

Parameters:
- N_ITEMS, 13, number of items; mask bit i = item i.
- N_DIMS, 2, number of cost constraints (dim 0 = value; dims 1..N_DIMS = costs).
- COEF_W, 8, coefficient width (unsigned).
- ACC_W, derived localparam COEF_W+$clog2(N_ITEMS+1), sum/limit width; sums never wrap.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- cfg_we  in  1  coefficient write strobe.
- cfg_item  in  $clog2(N_ITEMS)  item index.
- cfg_dim  in  $clog2(N_DIMS+1)  0 = value, k = cost k.
- cfg_data  in  COEF_W  coefficient.
- lim_we  in  1  limit write strobe.
- lim_dim  in  $clog2(N_DIMS+1)  0 = min value, k = max cost k.
- lim_data  in  ACC_W  limit.
- start  in  1  begin sweep (accepted only when idle).
- busy  out  1  sweep in progress.
- done  out  1  one-cycle completion pulse.
- best_valid  out  1  at least one feasible subset found.
- best_mask  out  N_ITEMS  best subset.
- best_value  out  ACC_W  value of best subset.
- feas_count  out  N_ITEMS+1  number of feasible subsets (see Optional Feature).

Behaviour:
- Reset:
  - All coefficients and limits are 0.
  - busy=0, done=0, best_valid=0, best_mask=0, best_value=0, feas_count=0.
  - Reset asserted mid-sweep aborts immediately; all of the above is restored.
- FSM states: IDLE, SWEEP, DRAIN, DONE.
  - IDLE: start=1 → SWEEP, cnt=0, best_*/feas_count cleared; busy=1 from the next cycle.
  - SWEEP: each cycle stage 1 registers the sums for mask=cnt, then cnt++. After cnt=2^N_ITEMS-1 is issued → DRAIN.
  - DRAIN: stage 2 processes the last mask → DONE.
  - DONE: done=1 for one cycle, busy=0 → IDLE.
- Latency: done is high in the cycle 2^N_ITEMS+2 edges after the start-accept edge. Throughput is one subset per cycle.
- Stage 1: for each dim, sum of coefficients selected by the mask, computed at ACC_W width. Zero extension only.
- Stage 2 feasibility: value ≥ lim[0] AND cost_k ≤ lim[k] for all k.
  - If feasible and (!best_valid OR value > best_value): update best_mask and best_value, set best_valid.
  - Ties keep the earlier (lower) mask. The empty mask is evaluated like any other.
- Results are held stable from done until the next accepted start.
- Writes:
  - cfg_we and lim_we are ignored while busy=1.
  - In IDLE, a write takes effect at the next edge.
  - Out-of-range cfg_item or dim indices are ignored.
  - A write and start in the same IDLE cycle: the write lands first; the sweep uses the new value.
- start while busy is ignored. start held high re-triggers only after returning to IDLE.
- The cnt register is N_ITEMS+1 bits so the terminal compare cannot wrap.

Optional Feature:
- Macro: KNAP_FEAS_COUNT_EN.
- Defined: feas_count increments in stage 2 for every feasible mask. It saturates at 2^N_ITEMS, which is reachable and fits.
- Undefined: counter logic is omitted and feas_count is tied to 0. The port remains present.

Decomposition:
- Package knap_pkg holds:
  - the state_t enum {IDLE, SWEEP, DRAIN, DONE};
  - the DIM_VALUE=0 constant;
  - an acc-width function shared by the bench for golden-model sizing.
- Sub-module knap_subset_sum: one instance per dimension (N_DIMS+1 via generate).
  - Inputs: mask and a coefficient column.
  - Output: a registered ACC_W sum.
  - This is stage 1.

Test Plan (N_ITEMS=4, N_DIMS=2, COEF_W=8 unless noted):
- Basic solve:
  - Stimulus: values {4,8,0,20}, weights {28,8,27,18}, volumes {27,27,4,4}; limits min=10, maxW=30, maxV=35; start.
  - Required: done 18 cycles after start; best_valid=1, best_mask=4'b1010, best_value=28, feas_count=2 (with the _EN macro).
- Infeasible: same data with min=100 → best_valid=0, best_mask=0, best_value=0, feas_count=0.
- Tie-break: values {5,5,0,0}, weights {10,10,0,0}, maxW=10, min=1, maxV=255 → best_mask=4'b0001, best_value=5.
- No wrap: all coefficients 255, min=0, maxW=maxV=1020 → best_mask=4'b1111, best_value=1020, feas_count=16.
- Busy protection: during the sweep, pulse start and write value[3]=200.
  - Result matches the basic solve.
  - A second start then yields best_value=208 for mask 4'b1010.
- Reset mid-sweep: assert rst at cycle 7.
  - All outputs and config are 0.
  - The next start with config unloaded gives best_valid=1, best_mask=0, best_value=0.
